// File: rtl/apb_master_core.sv
// APB requester: turns a valid/ready command stream into APB
// SETUP/ACCESS transfers, one pulsed response per command.
module apb_master_core #(
  parameter int APB_BUS_W   = 32,
  parameter int APB_ADDR_W  = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [APB_BUS_W-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  output logic [APB_BUS_W-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic [APB_BUS_W-1:0]  pwdata,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  input  logic                  pready,
  input  logic [APB_BUS_W-1:0]  prdata
);

  localparam int CW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CW-1:0] CNT_MAX =
    CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [APB_ADDR_W-1:0] paddr_d;
  logic [APB_BUS_W-1:0]  pwdata_d;
  logic                  pwrite_d;
  logic                  rsp_valid_d;
  logic                  rsp_err_d;
  logic [APB_BUS_W-1:0]  rsp_rdata_d;

  // Bus controls decode straight from the state flop
  assign cmd_ready = (state_q == IDLE);
  assign psel      = (state_q != IDLE);
  assign penable   = (state_q == ACCESS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    pwrite_d    = pwrite;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite ? '0 : prdata;
          state_d     = IDLE;
        end else if (TO_EN && cnt_q == CNT_MAX) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      pwrite    <= pwrite_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule
